// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks the microcode table, issues registered datapath
// strobes and picks each next micro-address (increment, dispatch, loop, end).
module micro_sequencer #(
  parameter int unsigned bit_depth      = 8,
  parameter int unsigned log_port_depth = 5,
  parameter int unsigned table_depth    = 20,
  parameter int unsigned iter_width     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [1:0]                instr_opcode,
  input  logic [iter_width-1:0]     instr_count,
  output logic [log_port_depth-1:0] ut_address,
  output logic                      ut_read_en,
  input  logic [bit_depth-1:0]      ut_data,
  output logic [3:0]                ctrl,
  output logic                      ctrl_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned addr_w = log_port_depth;
  localparam int unsigned ext_w  = log_port_depth + 1;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {SEQ_NEXT, SEQ_DISPATCH, SEQ_LOOP, SEQ_END} seq_op_t;

  state_t                state, state_nx;
  logic [addr_w-1:0]     upc, upc_nx;
  logic [addr_w-1:0]     loop_base, loop_base_nx;
  logic [iter_width-1:0] cnt, cnt_nx;
  logic [1:0]            opcode, opcode_nx;
  logic [3:0]            ctrl_nx;
  logic                  ctrl_valid_nx, done_nx, err_nx;
  seq_op_t               seq_op;
  logic [addr_w-1:0]     dispatch_addr;
  logic [ext_w-1:0]      target;
  logic                  unused_data;

  assign seq_op      = seq_op_t'(ut_data[7:6]);
  assign unused_data = ^ut_data;

  assign instr_ready = (state == IDLE);
  assign ut_read_en  = (state == RUN);
  assign busy        = (state == RUN);
  assign ut_address  = (state == RUN) ? upc : '0;

  // Opcode to microroutine entry point
  always_comb begin
    case (opcode)
      2'b00:   dispatch_addr = addr_w'(8);
      2'b01:   dispatch_addr = addr_w'(2);
      2'b10:   dispatch_addr = addr_w'(16);
      default: dispatch_addr = addr_w'(18);
    endcase
  end

  // Next-state, next-address and strobe decode; target carries one extra bit
  // so that a wrap past the top of the address space is caught as illegal.
  always_comb begin
    state_nx      = state;
    upc_nx        = upc;
    loop_base_nx  = loop_base;
    cnt_nx        = cnt;
    opcode_nx     = opcode;
    ctrl_nx       = ctrl;
    ctrl_valid_nx = 1'b0;
    done_nx       = 1'b0;
    err_nx        = err;
    target        = {1'b0, upc} + ext_w'(1);

    if (state == IDLE) begin
      if (instr_valid) begin
        state_nx  = RUN;
        upc_nx    = '0;
        opcode_nx = instr_opcode;
        cnt_nx    = (instr_count == '0) ? iter_width'(1) : instr_count;
        err_nx    = 1'b0;
      end
    end else begin
      ctrl_nx       = ut_data[3:0];
      ctrl_valid_nx = 1'b1;
      case (seq_op)
        SEQ_DISPATCH: begin
          target       = {1'b0, dispatch_addr};
          loop_base_nx = dispatch_addr;
        end
        SEQ_LOOP: begin
          if (cnt > iter_width'(1)) begin
            cnt_nx = cnt - iter_width'(1);
            target = {1'b0, loop_base};
          end
        end
        default: ;
      endcase

      if (seq_op == SEQ_END) begin
        state_nx = IDLE;
        upc_nx   = '0;
        done_nx  = 1'b1;
      end else if (target >= ext_w'(table_depth)) begin
        state_nx = IDLE;
        upc_nx   = '0;
        err_nx   = 1'b1;
      end else begin
        upc_nx = target[addr_w-1:0];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      upc        <= '0;
      loop_base  <= '0;
      cnt        <= '0;
      opcode     <= '0;
      ctrl       <= '0;
      ctrl_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      upc        <= upc_nx;
      loop_base  <= loop_base_nx;
      cnt        <= cnt_nx;
      opcode     <= opcode_nx;
      ctrl       <= ctrl_nx;
      ctrl_valid <= ctrl_valid_nx;
      done       <= done_nx;
      err        <= err_nx;
    end
  end

endmodule
